// File: rtl/pipo_pkg.sv
// Shared types and helpers for the universal PIPO register and its shift counter.
package pipo_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Counter width for a modulo-width count; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/pipo_universal_reg_shift_cnt.sv
// Modulo-WIDTH shift counter with synchronous clear and a registered wrap pulse.
module shift_cnt
    import pipo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Clear outranks increment so a load landing on a completing shift never pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + ONE;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/pipo_universal_reg.sv
// WIDTH-bit universal register: hold, shift right, shift left, parallel load,
// with a word-completion counter for serial assembly and draining.
module pipo_universal_reg
    import pipo_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    mode_e            op;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] data;

    assign op    = mode_e'(mode);
    assign load  = en && (op == MODE_LOAD);
    assign shift = en && ((op == MODE_SHR) || (op == MODE_SHL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= RESET_VAL;
        end else if (sclr) begin
            data <= RESET_VAL;
        end else if (en) begin
            case (op)
                MODE_SHR:  data <= {sin_r, data[WIDTH-1:1]};
                MODE_SHL:  data <= {data[WIDTH-2:0], sin_l};
                MODE_LOAD: data <= parallel_in;
                default:   data <= data;
            endcase
        end
    end

    // Loads restart the word count just like a clear does.
    shift_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (sclr | load),
        .inc   (shift),
        .cnt   (bit_cnt),
        .wrap  (word_done)
    );

    assign parallel_out = data;
    assign sout_r       = data[0];
    assign sout_l       = data[WIDTH-1];

endmodule

// File: tb/tb_pipo_universal_reg.sv
// Self-checking bench: directed scenarios plus random traffic against an arithmetic model.
module tb_pipo_universal_reg;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         sclr;
    logic         en;
    logic [1:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] parallel_in;
    logic [W-1:0] parallel_out;
    logic         sout_r;
    logic         sout_l;
    logic [1:0]   bit_cnt;
    logic         word_done;

    int total = 0;
    int bad   = 0;
    bit compare_on = 1'b0;

    int m_val    = 0;
    int m_shifts = 0;
    int m_done   = 0;

    pipo_universal_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclr         (sclr),
        .en           (en),
        .mode         (mode),
        .sin_r        (sin_r),
        .sin_l        (sin_l),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out),
        .sout_r       (sout_r),
        .sout_l       (sout_l),
        .bit_cnt      (bit_cnt),
        .word_done    (word_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: value as an integer, shifts counted modulo W since last load/clear.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_val    <= 0;
            m_shifts <= 0;
            m_done   <= 0;
        end else if (sclr) begin
            m_val    <= 0;
            m_shifts <= 0;
            m_done   <= 0;
        end else if (en && mode == 2'b11) begin
            m_val    <= int'(parallel_in);
            m_shifts <= 0;
            m_done   <= 0;
        end else if (en && (mode == 2'b01 || mode == 2'b10)) begin
            if (mode == 2'b01)
                m_val <= (m_val / 2) + int'(sin_r) * (1 << (W - 1));
            else
                m_val <= (m_val * 2 + int'(sin_l)) % (1 << W);
            m_shifts <= (m_shifts + 1) % W;
            m_done   <= ((m_shifts + 1) % W == 0) ? 1 : 0;
        end else begin
            m_done <= 0;
        end
    end

    task automatic check_output(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_on) begin
            check_output("cyc_parallel_out", int'(parallel_out), m_val);
            check_output("cyc_sout_r", int'(sout_r), m_val % 2);
            check_output("cyc_sout_l", int'(sout_l), (m_val >> (W - 1)) % 2);
            check_output("cyc_bit_cnt", int'(bit_cnt), m_shifts);
            check_output("cyc_word_done", int'(word_done), m_done);
        end
    end

    // Drives one operation and returns just after the edge that applied it.
    task automatic apply_stimulus(input bit e, input bit [1:0] m, input bit sr, input bit sl,
                                  input bit [W-1:0] pin, input bit clr);
        en          = e;
        mode        = m;
        sin_r       = sr;
        sin_l       = sl;
        parallel_in = pin;
        sclr        = clr;
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int first_pulse;
    int second_pulse;
    bit [3:0] sipo_bits;
    bit [3:0] piso_exp;

    initial begin
        reset = 1'b1; sclr = 1'b0; en = 1'b0; mode = 2'b00;
        sin_r = 1'b0; sin_l = 1'b0; parallel_in = '0;
        #2 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        compare_on = 1'b1;
        @(posedge clk); #1;
        check_output("reset_po", int'(parallel_out), 0);
        check_output("reset_cnt", int'(bit_cnt), 0);
        check_output("reset_done", int'(word_done), 0);

        // PIPO
        apply_stimulus(1, 2'b11, 0, 0, 4'h9, 0);
        check_output("pipo_load", int'(parallel_out), 'h9);
        apply_stimulus(1, 2'b00, 0, 0, 4'h3, 0);
        check_output("pipo_hold", int'(parallel_out), 'h9);

        // SIPO
        apply_stimulus(1, 2'b11, 0, 0, 4'h0, 0);
        sipo_bits = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 2'b10, 0, sipo_bits[i], 4'h0, 0);
            check_output("sipo_cnt", int'(bit_cnt), (i + 1) % 4);
            check_output("sipo_done", int'(word_done), (i == 3) ? 1 : 0);
        end
        check_output("sipo_word", int'(parallel_out), 'hB);
        check_output("model_sipo", m_val, 'hB);
        apply_stimulus(1, 2'b00, 0, 0, 4'h0, 0);
        check_output("sipo_done_drop", int'(word_done), 0);

        // PISO
        apply_stimulus(1, 2'b11, 0, 0, 4'h6, 0);
        piso_exp = 4'b0110;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            check_output("piso_sout_r", int'(sout_r), int'(piso_exp[i]));
            apply_stimulus(1, 2'b01, 0, 0, 4'h0, 0);
            if (word_done) pulses++;
        end
        check_output("piso_empty", int'(parallel_out), 0);
        check_output("piso_pulses", pulses, 1);

        // Priority
        apply_stimulus(1, 2'b11, 0, 0, 4'h7, 0);
        apply_stimulus(1, 2'b01, 0, 0, 4'h0, 0);
        check_output("prio_pre_po", int'(parallel_out), 'h3);
        apply_stimulus(1, 2'b11, 0, 0, 4'hF, 1);
        check_output("prio_sclr_po", int'(parallel_out), 0);
        check_output("prio_sclr_cnt", int'(bit_cnt), 0);
        apply_stimulus(1, 2'b11, 0, 0, 4'hC, 0);
        apply_stimulus(1, 2'b10, 0, 0, 4'h0, 0);
        apply_stimulus(0, 2'b01, 1, 1, 4'h5, 0);
        check_output("prio_en0_po", int'(parallel_out), 'h8);
        check_output("prio_en0_cnt", int'(bit_cnt), 1);

        // Wrap collision
        apply_stimulus(1, 2'b11, 0, 0, 4'h0, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 2'b01, 1, 0, 4'h0, 0);
            if (word_done) pulses++;
        end
        apply_stimulus(1, 2'b11, 0, 0, 4'h5, 0);
        if (word_done) pulses++;
        check_output("coll_po", int'(parallel_out), 'h5);
        check_output("coll_cnt", int'(bit_cnt), 0);
        apply_stimulus(1, 2'b00, 0, 0, 4'h0, 0);
        if (word_done) pulses++;
        check_output("coll_no_done", pulses, 0);
        first_pulse = -1; second_pulse = -1;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, (i % 2 == 0) ? 2'b01 : 2'b10, i % 2, 1, 4'h0, 0);
            if (word_done) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i; else second_pulse = i;
            end
        end
        check_output("b2b_pulses", pulses, 2);
        check_output("b2b_gap", second_pulse - first_pulse, 4);

        // Asynchronous reset mid-shift
        apply_stimulus(1, 2'b11, 0, 0, 4'h2, 0);
        apply_stimulus(1, 2'b10, 0, 1, 4'h0, 0);
        apply_stimulus(1, 2'b10, 0, 0, 4'h0, 0);
        check_output("mid_pre_po", int'(parallel_out), 'hA);
        en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_output("async_po", int'(parallel_out), 0);
        check_output("async_cnt", int'(bit_cnt), 0);
        check_output("async_done", int'(word_done), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 2'b10, 0, 1, 4'h0, 0);
            check_output("restart_done", int'(word_done), (i == 3) ? 1 : 0);
        end

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           W'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        compare_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
